traffic_sequencer: RTL

Moore state machine that sequences the main-street and side-street lamps and the pedestrian walk lamp at a timed intersection. It consumes the latched walk request produced by the walk-request register and the synchronised side-street sensor, and it issues the one-cycle `WalkReg_Reset` pulse that clears that register once the request is served. Timing comes from an internal prescaler and seconds counter, so no external timer block is needed.

---
 rtl/traffic_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/traffic_sequencer.sv
// traffic_sequencer: Moore FSM sequencing main/side street lamps and the pedestrian walk lamp.
// Timing is derived from an internal prescaler (pcnt, one tick per TICK_DIV cycles) and a
// seconds counter (scnt). Both counters clear on every state change.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   WalkReq        latched walk request (level)
//   Sensor         side-street vehicle present
//   WalkReg_Reset  one-cycle clear pulse to the walk-request register (first cycle of WK)
//   Main_Light     main lamps {Red, Yellow, Green}
//   Side_Light     side lamps {Red, Yellow, Green}
//   Walk           pedestrian walk lamp
//   State_Out      current state encoding
module traffic_sequencer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned T_BASE   = 6,
  parameter int unsigned T_EXT    = 3,
  parameter int unsigned T_YEL    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       WalkReq,
  input  logic       Sensor,
  output logic       WalkReg_Reset,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk,
  output logic [2:0] State_Out
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMax = (T_BASE > T_EXT) ? ((T_BASE > T_YEL) ? T_BASE : T_YEL)
                                                  : ((T_EXT > T_YEL) ? T_EXT : T_YEL);
  localparam int unsigned SW   = $clog2(TMax + 1);

  typedef enum logic [2:0] {
    StMg1 = 3'd0,
    StMg2 = 3'd1,
    StMy  = 3'd2,
    StWk  = 3'd3,
    StSg  = 3'd4,
    StSg2 = 3'd5,
    StSy  = 3'd6,
    StBad = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pcnt_q;
  logic [SW-1:0]   scnt_q;
  logic [SW-1:0]   dur;
  logic            tick;
  logic            expire;
  logic            mg2_ext_q;    // MG2 runs for T_EXT instead of T_BASE
  logic            walk_pulse_q;

  assign tick = (pcnt_q == PW'(TICK_DIV - 1));

  // Duration in seconds of the current state.
  always_comb begin
    dur = SW'(T_BASE);
    case (state_q)
      StMg1:   dur = SW'(T_BASE);
      StMg2:   dur = mg2_ext_q ? SW'(T_EXT) : SW'(T_BASE);
      StMy:    dur = SW'(T_YEL);
      StWk:    dur = SW'(T_EXT);
      StSg:    dur = SW'(T_BASE);
      StSg2:   dur = SW'(T_EXT);
      StSy:    dur = SW'(T_YEL);
      default: dur = SW'(T_BASE);
    endcase
  end

  assign expire = tick && (scnt_q == (dur - 1'b1));

  // Next-state logic; inputs only matter on the expiry cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StMg1:   if (expire) state_d = StMg2;
      StMg2:   if (expire) state_d = StMy;
      StMy:    if (expire) state_d = WalkReq ? StWk : StSg;
      StWk:    if (expire) state_d = StSg;
      StSg:    if (expire) state_d = Sensor ? StSg2 : StSy;
      StSg2:   if (expire) state_d = StSy;
      StSy:    if (expire) state_d = StMg1;
      default: state_d = StMg1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StMg1;
      pcnt_q       <= '0;
      scnt_q       <= '0;
      mg2_ext_q    <= 1'b0;
      walk_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      walk_pulse_q <= (state_d == StWk) && (state_q != StWk);
      if (state_d != state_q) begin
        pcnt_q <= '0;
        scnt_q <= '0;
      end else if (tick) begin
        pcnt_q <= '0;
        scnt_q <= scnt_q + 1'b1;
      end else begin
        pcnt_q <= pcnt_q + 1'b1;
      end
      if ((state_q == StMg1) && expire) begin
        mg2_ext_q <= Sensor;
      end
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    Main_Light = 3'b100;
    Side_Light = 3'b100;
    Walk       = 1'b0;
    case (state_q)
      StMg1, StMg2: Main_Light = 3'b001;
      StMy:         Main_Light = 3'b010;
      StWk:         Walk       = 1'b1;
      StSg, StSg2:  Side_Light = 3'b001;
      StSy:         Side_Light = 3'b010;
      default:      Main_Light = 3'b100;
    endcase
  end

  assign WalkReg_Reset = walk_pulse_q;
  assign State_Out     = state_q;

endmodule
